pwm_stream_dac: RTL
===================

// Module: pwm_stream_dac
// PURPOSE
//  Multi-channel successor to the FIFO->PWM adapter + pwmdac pair. Pulls interleaved samples from a
//  show-ahead FIFO (read side in clk110), paces them at a fixed sample rate, converts IN_W->PWM_W by
//  selectable mode, double-buffers a frame and drives one PWM pin per channel. Underruns are flagged.
// PARAMETERS
//  IN_W           16    FIFO sample width
//  PWM_W          8     PWM resolution; counter period 2**PWM_W clocks
//  NCH            1     channels per frame, channel 0 first in FIFO stream
//  SAMPLE_PERIOD  2500  clk110 cycles per frame (110 MHz / 44 kHz)
//  MUTE_ON_UR     0     1: underrun loads duty 0; 0: hold last duty
// PORTS
//  clk110        in   1        clock
//  RESET         in   1        synchronous, active-low reset
//  enable        in   1        run; low = idle, no FIFO reads, outputs low
//  mode          in   2        0 trunc, 1 odd-bit interleave, 2 round+sat, 3 signed->offset trunc
//  fifo_data     in   IN_W     show-ahead FIFO head, valid while fifo_empty_n
//  fifo_empty_n  in   1        FIFO holds data
//  fifo_rd       out  1        1-cycle pop pulse
//  pwm_out       out  NCH      PWM output per channel
//  frame_strobe  out  1        1-cycle pulse when a new frame is loaded to active duties
//  underrun      out  1        sticky underrun flag
//  underrun_clr  in   1        clears underrun (set wins if same cycle)
// BEHAVIOUR
//  Reset/disable: all outputs 0; tick/pwm counters 0; shadow/active/duty regs 0; FSM IDLE; primed=0.
//  Tick counter counts 0..SAMPLE_PERIOD-1 while enable; tick = count==SAMPLE_PERIOD-1.
//  FSM IDLE -> FETCH when enable. FETCH, ch idx k: if fifo_empty_n & !rd_last: shadow[k]<=conv(fifo_data),
//   fifo_rd=1, k++. rd_last = fifo_rd of previous cycle (no back-to-back pops; max 1 sample / 2 clks).
//   After k==NCH-1 pop -> FULL (frame_ready=1). FIFO empty: FETCH stalls, no pop.
//  On tick: if frame_ready: active<=shadow, frame_strobe=1, frame_ready=0, primed=1, FSM->FETCH k=0.
//   else if primed: underrun<=1; active<=0 if MUTE_ON_UR else unchanged; FETCH continues at current k
//   (no channel slip; partial frame is completed, loaded on a later tick).
//  mode sampled at each pop (per sample). enable low at any point: abort frame, discard shadow, IDLE;
//   popped samples of a partial frame are lost. RESET mid-frame likewise.
//  conv, S=fifo_data, m=IN_W-PWM_W: mode0 S[IN_W-1:m]; mode1 {S[IN_W-1],S[IN_W-3],...} PWM_W bits
//   (requires IN_W>=2*PWM_W); mode2 S[IN_W-1:m]+S[m-1], saturate to 2**PWM_W-1; mode3 mode0 of
//   {~S[IN_W-1],S[IN_W-2:0]}.
//  PWM: free-running pwm_cnt 0..2**PWM_W-1; duty[c]<=active[c] only when pwm_cnt wraps to 0
//   (glitch-free); pwm_out[c] registered = (pwm_cnt < duty[c]). Duty 0 -> constant 0; max -> high
//   all but 1 clk. Latency sample pop -> pin: next tick, then next pwm wrap, +1 clk.
// TESTING (bench params PWM_W=4, IN_W=16, NCH=2, SAMPLE_PERIOD=64, MUTE_ON_UR=0)
//  1 mode0, FIFO 0x8000,0xF000 -> after tick+wrap ch0 high 8/16 clks, ch1 15/16; frame_strobe 1 pulse.
//  2 mode2 0x0FFF -> duty 1; 0xFFFF -> saturate 15; mode3 0x0000 -> 8, 0x8000 -> 0.
//  3 FIFO holds 1 sample after primed -> tick: underrun=1, duty held; push 2nd -> frame loads next tick.
//  4 MUTE_ON_UR=1, starve FIFO -> duties 0, pwm_out low; underrun_clr pulse clears flag.
//  5 FIFO always full -> fifo_rd never asserted on consecutive cycles; exactly 2 pops per 64 clks.
//  6 enable low mid-FETCH then RESET low 1 cycle -> all outputs 0, no pops; re-enable, first tick no underrun.

Source files
------------

// File: rtl/pwm_stream_dac.sv
// Multi-channel FIFO-fed PWM DAC: paces interleaved samples at a fixed frame rate,
// converts each to PWM_W bits, double-buffers a frame and drives one PWM pin per channel.
module pwm_stream_dac #(
  parameter int IN_W          = 16,
  parameter int PWM_W         = 8,
  parameter int NCH           = 1,
  parameter int SAMPLE_PERIOD = 2500,
  parameter bit MUTE_ON_UR    = 1'b0
) (
  input  logic            clk110,
  input  logic            RESET,
  input  logic            enable,
  input  logic [1:0]      mode,
  input  logic [IN_W-1:0] fifo_data,
  input  logic            fifo_empty_n,
  output logic            fifo_rd,
  output logic [NCH-1:0]  pwm_out,
  output logic            frame_strobe,
  output logic            underrun,
  input  logic            underrun_clr
);

  localparam int M      = IN_W - PWM_W;
  localparam int TICK_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int CH_W   = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_PERIOD - 1);
  localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NCH - 1);
  localparam logic [PWM_W-1:0]  PWM_MAX   = '1;
  localparam logic [PWM_W-1:0]  PWM_MSB   = PWM_W'(1) << (PWM_W - 1);

  // Sample width reduction; assumes IN_W > PWM_W, and IN_W >= 2*PWM_W for the interleave mode.
  function automatic logic [PWM_W-1:0] conv(input logic [IN_W-1:0] s, input logic [1:0] md);
    logic [PWM_W-1:0] hi;
    logic [PWM_W:0]   sum;
    logic [PWM_W-1:0] r;
    hi  = s[IN_W-1:M];
    sum = {1'b0, hi} + (PWM_W + 1)'(s[M-1]);
    r   = hi;
    case (md)
      2'd0: r = hi;
      2'd1: for (int i = 0; i < PWM_W; i++) r[PWM_W-1-i] = s[IN_W-1-2*i];
      2'd2: r = sum[PWM_W] ? PWM_MAX : sum[PWM_W-1:0];
      default: r = hi ^ PWM_MSB;
    endcase
    return r;
  endfunction

  logic [1:0]                 state_q, state_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic                       rd_last_q, rd_last_d;
  logic [TICK_W-1:0]          tick_cnt_q, tick_cnt_d;
  logic [PWM_W-1:0]           pwm_cnt_q, pwm_cnt_d;
  logic [NCH-1:0][PWM_W-1:0]  shadow_q, shadow_d;
  logic [NCH-1:0][PWM_W-1:0]  active_q, active_d;
  logic [NCH-1:0][PWM_W-1:0]  duty_q, duty_d;
  logic [NCH-1:0]             pwm_out_q, pwm_out_d;
  logic                       strobe_q, strobe_d;
  logic                       underrun_q, underrun_d;
  logic                       primed_q, primed_d;
  logic                       tick;

  assign tick    = enable & (tick_cnt_q == TICK_LAST);
  // Pops are spaced at least one idle cycle apart so the FIFO head has time to advance.
  assign fifo_rd = RESET & enable & (state_q == ST_FETCH) & fifo_empty_n & ~rd_last_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path through this block can infer a latch.
    state_d    = state_q;
    ch_d       = ch_q;
    shadow_d   = shadow_q;
    active_d   = active_q;
    duty_d     = duty_q;
    primed_d   = primed_q;
    strobe_d   = 1'b0;
    rd_last_d  = fifo_rd;
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    pwm_cnt_d  = pwm_cnt_q + PWM_W'(1);
    underrun_d = underrun_q & ~underrun_clr;

    // Duties only change at the period boundary, so a pulse is never cut short or doubled.
    if (pwm_cnt_q == PWM_MAX) duty_d = active_q;
    for (int c = 0; c < NCH; c++) pwm_out_d[c] = (pwm_cnt_q < duty_q[c]);

    case (state_q)
      ST_IDLE: begin
        state_d = ST_FETCH;
        ch_d    = '0;
      end
      ST_FETCH: begin
        if (fifo_rd) begin
          shadow_d[ch_q] = conv(fifo_data, mode);
          if (ch_q == CH_LAST) begin
            state_d = ST_FULL;
            ch_d    = '0;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end
      end
      default: ;
    endcase

    if (tick) begin
      if (state_q == ST_FULL) begin
        active_d = shadow_q;
        strobe_d = 1'b1;
        primed_d = 1'b1;
        state_d  = ST_FETCH;
        ch_d     = '0;
      end else if (primed_q) begin
        // Fetch keeps its channel position so a late sample still lands in the right slot.
        underrun_d = 1'b1;
        if (MUTE_ON_UR) active_d = '0;
      end
    end

    if (!enable) begin
      state_d    = ST_IDLE;
      ch_d       = '0;
      tick_cnt_d = '0;
      pwm_cnt_d  = '0;
      shadow_d   = '0;
      active_d   = '0;
      duty_d     = '0;
      pwm_out_d  = '0;
      strobe_d   = 1'b0;
      underrun_d = 1'b0;
      primed_d   = 1'b0;
    end
  end

  // NOTE: the sample arrays are a handful of flops with a defined cleared state, so they are reset like the rest.
  always_ff @(posedge clk110) begin
    if (!RESET) begin
      state_q    <= ST_IDLE;
      ch_q       <= '0;
      rd_last_q  <= 1'b0;
      tick_cnt_q <= '0;
      pwm_cnt_q  <= '0;
      shadow_q   <= '0;
      active_q   <= '0;
      duty_q     <= '0;
      pwm_out_q  <= '0;
      strobe_q   <= 1'b0;
      underrun_q <= 1'b0;
      primed_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of the others.
      state_q    <= state_d;
      ch_q       <= ch_d;
      rd_last_q  <= rd_last_d;
      tick_cnt_q <= tick_cnt_d;
      pwm_cnt_q  <= pwm_cnt_d;
      shadow_q   <= shadow_d;
      active_q   <= active_d;
      duty_q     <= duty_d;
      pwm_out_q  <= pwm_out_d;
      strobe_q   <= strobe_d;
      underrun_q <= underrun_d;
      primed_q   <= primed_d;
    end
  end

  assign pwm_out      = pwm_out_q;
  assign frame_strobe = strobe_q;
  assign underrun     = underrun_q;

endmodule
